// File: rtl/dmac_channel_engine.sv
// DMA channel datapath: source/destination address and beat counters, FWFT FIFO, burst sizing, write strobes.
// Define DMAC_BOUNDARY_SPLIT_EN to break incrementing bursts that would cross a 1 KB boundary into SINGLE beats.
module dmac_channel_engine #(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 16,
    parameter int MAX_BURST  = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            cfg_load,
    input  logic [31:0]                     cfg_src,
    input  logic [31:0]                     cfg_dst,
    input  logic [31:0]                     cfg_beats,
    input  logic [4:0]                      cfg_burst,
    input  logic [1:0]                      cfg_hsize,
    input  logic                            cfg_src_inc,
    input  logic                            cfg_dst_inc,
    input  logic                            rd_burst_start,
    input  logic                            wr_burst_start,
    input  logic                            rd_beat,
    input  logic                            wr_beat,
    input  logic [DATA_W-1:0]               r_data,
    output logic [31:0]                     src_addr,
    output logic [31:0]                     dst_addr,
    output logic [2:0]                      rd_hburst,
    output logic [2:0]                      wr_hburst,
    output logic                            rd_burst_last,
    output logic                            wr_burst_last,
    output logic                            rd_done,
    output logic                            wr_done,
    output logic                            rd_space_ok,
    output logic                            wr_data_ok,
    output logic [DATA_W-1:0]               w_data,
    output logic [DATA_W/8-1:0]             w_strb,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
    output logic                            fifo_full,
    output logic                            fifo_empty,
    output logic                            ovf_err,
    output logic                            unf_err
);

    localparam int STRB_W = DATA_W / 8;
    localparam int LANE_W = $clog2(STRB_W);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int LVL_W  = PTR_W + 1;

    logic [4:0]        burst_q;
    logic [1:0]        hsize_q;
    logic              src_inc_q, dst_inc_q;
    logic [31:0]       src_q, dst_q, rd_rem_q, wr_rem_q;
    logic [4:0]        rd_cnt_q, wr_cnt_q;
    logic [2:0]        rd_hb_q, wr_hb_q;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
    logic [LVL_W-1:0]  level_q;
    logic              ovf_q, unf_q, byp_q;
    logic [DATA_W-1:0] byp_data_q;

    logic [31:0]       beat_bytes;
    logic [4:0]        rd_len, wr_len;
    logic              rd_cross, wr_cross;
    logic              push, pop, mem_we;
    logic              lane_aligned, size_fits;
    logic [STRB_W-1:0] strb_raw;

    function automatic logic [4:0] norm_burst(input logic [4:0] b);
        if ((b == 5'd4 || b == 5'd8 || b == 5'd16) && int'(b) <= MAX_BURST)
            return b;
        return 5'd1;
    endfunction

    function automatic logic [2:0] hburst_enc(input logic [4:0] len);
        case (len)
            5'd4:    return 3'b011;
            5'd8:    return 3'b101;
            5'd16:   return 3'b111;
            default: return 3'b000;
        endcase
    endfunction

    assign beat_bytes = 32'd1 << hsize_q;

`ifdef DMAC_BOUNDARY_SPLIT_EN
    logic [10:0] span;
    assign span     = 11'(burst_q) << hsize_q;
    assign rd_cross = (11'(src_q[9:0]) + span) > 11'd1024;
    assign wr_cross = (11'(dst_q[9:0]) + span) > 11'd1024;
`else
    assign rd_cross = 1'b0;
    assign wr_cross = 1'b0;
`endif

    // Pending length for the next burst; fixed-address sides never burst
    assign rd_len = (src_inc_q && rd_rem_q >= 32'(burst_q) && !rd_cross) ? burst_q : 5'd1;
    assign wr_len = (dst_inc_q && wr_rem_q >= 32'(burst_q) && !wr_cross) ? burst_q : 5'd1;

    assign rd_done = (rd_rem_q == 32'd0);
    assign wr_done = (wr_rem_q == 32'd0);
    assign push    = rd_beat && !rd_done;
    assign pop     = wr_beat && !wr_done;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            burst_q   <= 5'd1;
            hsize_q   <= '0;
            src_inc_q <= 1'b0;
            dst_inc_q <= 1'b0;
            src_q     <= '0;
            dst_q     <= '0;
            rd_rem_q  <= '0;
            wr_rem_q  <= '0;
            rd_cnt_q  <= '0;
            wr_cnt_q  <= '0;
            rd_hb_q   <= '0;
            wr_hb_q   <= '0;
        end else if (cfg_load) begin
            burst_q   <= norm_burst(cfg_burst);
            hsize_q   <= cfg_hsize;
            src_inc_q <= cfg_src_inc;
            dst_inc_q <= cfg_dst_inc;
            src_q     <= cfg_src;
            dst_q     <= cfg_dst;
            rd_rem_q  <= cfg_beats;
            wr_rem_q  <= cfg_beats;
            rd_cnt_q  <= '0;
            wr_cnt_q  <= '0;
            rd_hb_q   <= '0;
            wr_hb_q   <= '0;
        end else begin
            if (push) begin
                if (src_inc_q)
                    src_q <= src_q + beat_bytes;
                rd_rem_q <= rd_rem_q - 32'd1;
            end
            if (pop) begin
                if (dst_inc_q)
                    dst_q <= dst_q + beat_bytes;
                wr_rem_q <= wr_rem_q - 32'd1;
            end
            // A beat coinciding with burst start counts as the burst's first beat
            if (rd_burst_start) begin
                rd_hb_q  <= hburst_enc(rd_len);
                rd_cnt_q <= (push && rd_len != 5'd1) ? rd_len - 5'd2 : rd_len - 5'd1;
            end else if (push && rd_cnt_q != 5'd0) begin
                rd_cnt_q <= rd_cnt_q - 5'd1;
            end
            if (wr_burst_start) begin
                wr_hb_q  <= hburst_enc(wr_len);
                wr_cnt_q <= (pop && wr_len != 5'd1) ? wr_len - 5'd2 : wr_len - 5'd1;
            end else if (pop && wr_cnt_q != 5'd0) begin
                wr_cnt_q <= wr_cnt_q - 5'd1;
            end
        end
    end

    assign fifo_empty = (level_q == '0);
    assign fifo_full  = (level_q == LVL_W'(FIFO_DEPTH));

    // Push+pop on an empty FIFO goes through the bypass register instead of storage
    assign mem_we = !cfg_load && push && (pop ? !fifo_empty : !fifo_full);

    always_ff @(posedge clk) begin
        if (mem_we)
            mem[wr_ptr_q] <= r_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            level_q    <= '0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            byp_q      <= 1'b0;
            byp_data_q <= '0;
        end else if (cfg_load) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            level_q    <= '0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            byp_q      <= 1'b0;
        end else begin
            byp_q <= push && pop && fifo_empty;
            if (push && pop && fifo_empty)
                byp_data_q <= r_data;
            case ({push, pop})
                2'b11: begin
                    if (!fifo_empty) begin
                        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                    end
                end
                2'b10: begin
                    if (fifo_full) begin
                        ovf_q <= 1'b1;
                    end else begin
                        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                        level_q  <= level_q + LVL_W'(1);
                    end
                end
                2'b01: begin
                    if (fifo_empty) begin
                        unf_q <= 1'b1;
                    end else begin
                        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                        level_q  <= level_q - LVL_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign lane_aligned = (32'(dst_q[LANE_W-1:0]) & (beat_bytes - 32'd1)) == 32'd0;
    assign size_fits    = beat_bytes <= 32'(STRB_W);
    assign strb_raw     = STRB_W'((32'd1 << beat_bytes) - 32'd1) << dst_q[LANE_W-1:0];

    assign src_addr      = src_q;
    assign dst_addr      = dst_q;
    assign rd_hburst     = rd_hb_q;
    assign wr_hburst     = wr_hb_q;
    assign rd_burst_last = (rd_cnt_q == 5'd0);
    assign wr_burst_last = (wr_cnt_q == 5'd0);
    assign rd_space_ok   = (32'(FIFO_DEPTH) - 32'(level_q)) >= 32'(rd_len);
    assign wr_data_ok    = 32'(level_q) >= 32'(wr_len);
    assign w_data        = byp_q ? byp_data_q : (fifo_empty ? '0 : mem[rd_ptr_q]);
    assign w_strb        = (fifo_empty || !lane_aligned || !size_fits) ? '0 : strb_raw;
    assign fifo_level    = level_q;
    assign ovf_err       = ovf_q;
    assign unf_err       = unf_q;

endmodule

// File: tb/tb_dmac_channel_engine.sv
// Self-checking bench for dmac_channel_engine: queue-based reference model compared every cycle, plus directed literal checks.
module tb_dmac_channel_engine;

    localparam int DATA_W     = 32;
    localparam int FIFO_DEPTH = 16;
    localparam int MAX_BURST  = 16;
    localparam int STRB_W     = DATA_W / 8;
    localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1;

    logic              clk, rst, cfg_load;
    logic [31:0]       cfg_src, cfg_dst, cfg_beats;
    logic [4:0]        cfg_burst;
    logic [1:0]        cfg_hsize;
    logic              cfg_src_inc, cfg_dst_inc;
    logic              rd_burst_start, wr_burst_start, rd_beat, wr_beat;
    logic [DATA_W-1:0] r_data;
    logic [31:0]       src_addr, dst_addr;
    logic [2:0]        rd_hburst, wr_hburst;
    logic              rd_burst_last, wr_burst_last, rd_done, wr_done;
    logic              rd_space_ok, wr_data_ok;
    logic [DATA_W-1:0] w_data;
    logic [STRB_W-1:0] w_strb;
    logic [LVL_W-1:0]  fifo_level;
    logic              fifo_full, fifo_empty, ovf_err, unf_err;

    dmac_channel_engine #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .MAX_BURST(MAX_BURST)) dut (
        .clk(clk), .rst(rst), .cfg_load(cfg_load),
        .cfg_src(cfg_src), .cfg_dst(cfg_dst), .cfg_beats(cfg_beats),
        .cfg_burst(cfg_burst), .cfg_hsize(cfg_hsize),
        .cfg_src_inc(cfg_src_inc), .cfg_dst_inc(cfg_dst_inc),
        .rd_burst_start(rd_burst_start), .wr_burst_start(wr_burst_start),
        .rd_beat(rd_beat), .wr_beat(wr_beat), .r_data(r_data),
        .src_addr(src_addr), .dst_addr(dst_addr),
        .rd_hburst(rd_hburst), .wr_hburst(wr_hburst),
        .rd_burst_last(rd_burst_last), .wr_burst_last(wr_burst_last),
        .rd_done(rd_done), .wr_done(wr_done),
        .rd_space_ok(rd_space_ok), .wr_data_ok(wr_data_ok),
        .w_data(w_data), .w_strb(w_strb), .fifo_level(fifo_level),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty),
        .ovf_err(ovf_err), .unf_err(unf_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;
    int dseq, wseq;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state
    logic [31:0]       m_src, m_dst;
    longint            m_rrem, m_wrem;
    int                m_rcnt, m_wcnt, m_burst, m_hsize;
    logic [2:0]        m_rhb, m_whb;
    bit                m_sinc, m_dinc, m_ovf, m_unf, m_byp;
    logic [DATA_W-1:0] m_byp_data;
    logic [DATA_W-1:0] q[$];

    function automatic int exp_len(bit inc, longint rem, logic [31:0] addr, int burst, int hsize);
        if (!inc || rem < longint'(burst))
            return 1;
`ifdef DMAC_BOUNDARY_SPLIT_EN
        if (int'(addr % 32'd1024) + burst * (1 << hsize) > 1024)
            return 1;
`endif
        return burst;
    endfunction

    function automatic logic [2:0] exp_hb(int len);
        if (len == 4)  return 3'b011;
        if (len == 8)  return 3'b101;
        if (len == 16) return 3'b111;
        return 3'b000;
    endfunction

    function automatic int lit_len(logic [2:0] hb);
        if (hb == 3'b011) return 4;
        if (hb == 3'b101) return 8;
        if (hb == 3'b111) return 16;
        return 1;
    endfunction

    function automatic logic [STRB_W-1:0] exp_strb();
        logic [STRB_W-1:0] s;
        int bytes, lane;
        s = '0;
        bytes = 1 << m_hsize;
        lane = int'(m_dst % 32'(STRB_W));
        if (q.size() == 0 || bytes > STRB_W || (lane % bytes) != 0)
            return '0;
        for (int i = 0; i < STRB_W; i++)
            if (i >= lane && i < lane + bytes)
                s[i] = 1'b1;
        return s;
    endfunction

    always @(posedge clk or negedge rst) begin : model
        bit push, pop;
        int rl, wl;
        if (!rst) begin
            m_src = '0; m_dst = '0; m_rrem = 0; m_wrem = 0;
            m_rcnt = 0; m_wcnt = 0; m_burst = 1; m_hsize = 0;
            m_rhb = '0; m_whb = '0; m_sinc = 0; m_dinc = 0;
            m_ovf = 0; m_unf = 0; m_byp = 0; m_byp_data = '0;
            q.delete();
        end else if (cfg_load) begin
            m_src = cfg_src; m_dst = cfg_dst;
            m_rrem = longint'(cfg_beats); m_wrem = longint'(cfg_beats);
            m_burst = ((cfg_burst == 4 || cfg_burst == 8 || cfg_burst == 16) && int'(cfg_burst) <= MAX_BURST)
                      ? int'(cfg_burst) : 1;
            m_hsize = int'(cfg_hsize);
            m_sinc = cfg_src_inc; m_dinc = cfg_dst_inc;
            m_rcnt = 0; m_wcnt = 0; m_rhb = '0; m_whb = '0;
            m_ovf = 0; m_unf = 0; m_byp = 0;
            q.delete();
        end else begin
            push = rd_beat && m_rrem != 0;
            pop  = wr_beat && m_wrem != 0;
            rl = exp_len(m_sinc, m_rrem, m_src, m_burst, m_hsize);
            wl = exp_len(m_dinc, m_wrem, m_dst, m_burst, m_hsize);
            m_byp = 0;
            if (push && pop) begin
                if (q.size() == 0) begin
                    m_byp = 1;
                    m_byp_data = r_data;
                end else begin
                    void'(q.pop_front());
                    q.push_back(r_data);
                end
            end else if (push) begin
                if (q.size() == FIFO_DEPTH) m_ovf = 1;
                else q.push_back(r_data);
            end else if (pop) begin
                if (q.size() == 0) m_unf = 1;
                else void'(q.pop_front());
            end
            if (rd_burst_start) begin
                m_rhb = exp_hb(rl);
                m_rcnt = rl - 1 - (push ? 1 : 0);
                if (m_rcnt < 0) m_rcnt = 0;
            end else if (push && m_rcnt > 0) begin
                m_rcnt--;
            end
            if (wr_burst_start) begin
                m_whb = exp_hb(wl);
                m_wcnt = wl - 1 - (pop ? 1 : 0);
                if (m_wcnt < 0) m_wcnt = 0;
            end else if (pop && m_wcnt > 0) begin
                m_wcnt--;
            end
            if (push) begin
                if (m_sinc) m_src = m_src + 32'(1 << m_hsize);
                m_rrem--;
            end
            if (pop) begin
                if (m_dinc) m_dst = m_dst + 32'(1 << m_hsize);
                m_wrem--;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("src_addr", src_addr, m_src);
            check("dst_addr", dst_addr, m_dst);
            check("rd_done", rd_done, m_rrem == 0);
            check("wr_done", wr_done, m_wrem == 0);
            check("rd_burst_last", rd_burst_last, m_rcnt == 0);
            check("wr_burst_last", wr_burst_last, m_wcnt == 0);
            check("rd_hburst", rd_hburst, m_rhb);
            check("wr_hburst", wr_hburst, m_whb);
            check("rd_space_ok", rd_space_ok,
                  (FIFO_DEPTH - q.size()) >= exp_len(m_sinc, m_rrem, m_src, m_burst, m_hsize));
            check("wr_data_ok", wr_data_ok,
                  q.size() >= exp_len(m_dinc, m_wrem, m_dst, m_burst, m_hsize));
            check("w_data", w_data, m_byp ? m_byp_data : (q.size() > 0 ? q[0] : '0));
            check("w_strb", w_strb, exp_strb());
            check("fifo_level", fifo_level, q.size());
            check("fifo_full", fifo_full, q.size() == FIFO_DEPTH);
            check("fifo_empty", fifo_empty, q.size() == 0);
            check("ovf_err", ovf_err, m_ovf);
            check("unf_err", unf_err, m_unf);
        end
    end

    // Drive one cycle of handshakes; returns just after the following falling edge
    task automatic step(input bit rbs, input bit rb, input bit wbs, input bit wb, input logic [DATA_W-1:0] d);
        rd_burst_start = rbs; rd_beat = rb; wr_burst_start = wbs; wr_beat = wb; r_data = d;
        @(posedge clk);
        @(negedge clk);
        #1;
        rd_burst_start = 0; rd_beat = 0; wr_burst_start = 0; wr_beat = 0; r_data = '0;
    endtask

    task automatic load(input logic [31:0] src, input logic [31:0] dst, input logic [31:0] beats,
                        input logic [4:0] burst, input logic [1:0] hsize, input bit sinc, input bit dinc);
        cfg_src = src; cfg_dst = dst; cfg_beats = beats; cfg_burst = burst;
        cfg_hsize = hsize; cfg_src_inc = sinc; cfg_dst_inc = dinc; cfg_load = 1;
        @(posedge clk);
        @(negedge clk);
        #1;
        cfg_load = 0;
        dseq = 0;
        wseq = 0;
    endtask

    task automatic rd_burst(input logic [2:0] hb);
        int n;
        n = lit_len(hb);
        step(1, 0, 0, 0, '0);
        check("rd_hburst_seq", rd_hburst, hb);
        for (int i = 0; i < n; i++) begin
            step(0, 1, 0, 0, 32'hA000_0000 + 32'(dseq));
            dseq++;
        end
    endtask

    task automatic wr_burst(input logic [2:0] hb);
        int n;
        n = lit_len(hb);
        step(0, 0, 1, 0, '0);
        check("wr_hburst_seq", wr_hburst, hb);
        for (int i = 0; i < n; i++) begin
            check("w_data_order", w_data, 32'hA000_0000 + 32'(wseq));
            wseq++;
            step(0, 0, 0, 1, '0);
        end
    endtask

    task automatic run_basic();
        load(32'h100, 32'h2000, 32'd16, 5'd4, 2'd2, 1, 1);
        check("basic_space_ok", rd_space_ok, 1'b1);
        check("basic_data_ok0", wr_data_ok, 1'b0);
        repeat (4) rd_burst(3'b011);
        check("basic_src", src_addr, 32'h140);
        check("basic_level", fifo_level, 5'd16);
        repeat (4) wr_burst(3'b011);
        check("basic_dst", dst_addr, 32'h2040);
        check("basic_rd_done", rd_done, 1'b1);
        check("basic_wr_done", wr_done, 1'b1);
        check("basic_empty", fifo_empty, 1'b1);
    endtask

    logic [2:0] bl[$];

    initial begin
        rst = 0; cfg_load = 0; cfg_src = '0; cfg_dst = '0; cfg_beats = '0; cfg_burst = '0;
        cfg_hsize = '0; cfg_src_inc = 0; cfg_dst_inc = 0;
        rd_burst_start = 0; wr_burst_start = 0; rd_beat = 0; wr_beat = 0; r_data = '0;
        dseq = 0; wseq = 0;
        repeat (2) @(negedge clk);
        chk_en = 1;
        #1;
        check("rst_src", src_addr, 32'h0);
        check("rst_rd_done", rd_done, 1'b1);
        check("rst_wr_last", wr_burst_last, 1'b1);
        check("rst_hburst", rd_hburst, 3'b000);
        check("rst_empty", fifo_empty, 1'b1);
        check("rst_wstrb", w_strb, 4'b0000);
        rst = 1;

        run_basic();

        // Tail beats: one INCR8 then two SINGLE per side
        load(32'h0, 32'h800, 32'd10, 5'd8, 2'd2, 1, 1);
        rd_burst(3'b101); rd_burst(3'b000); rd_burst(3'b000);
        check("tail_rd_done", rd_done, 1'b1);
        check("tail_src", src_addr, 32'h28);
        wr_burst(3'b101); wr_burst(3'b000); wr_burst(3'b000);
        check("tail_wr_done", wr_done, 1'b1);

        // 1 KB boundary
        load(32'h3F8, 32'h3F8, 32'd8, 5'd4, 2'd2, 1, 1);
`ifdef DMAC_BOUNDARY_SPLIT_EN
        bl = '{3'b000, 3'b000, 3'b011, 3'b000, 3'b000};
`else
        bl = '{3'b011, 3'b011};
`endif
        foreach (bl[i]) rd_burst(bl[i]);
        foreach (bl[i]) wr_burst(bl[i]);
        check("bnd_src", src_addr, 32'h418);
        check("bnd_wr_done", wr_done, 1'b1);

        // Fixed address and unsupported burst request
        load(32'h40, 32'h80, 32'd8, 5'd4, 2'd2, 0, 0);
        rd_burst(3'b000);
        check("fixed_src", src_addr, 32'h40);
        load(32'h0, 32'h0, 32'd8, 5'd5, 2'd2, 1, 1);
        rd_burst(3'b000);

        // Byte strobes
        load(32'h0, 32'h1003, 32'd4, 5'd1, 2'd0, 1, 1);
        step(0, 1, 0, 0, 32'h11);
        check("strb_byte3", w_strb, 4'b1000);
        load(32'h0, 32'h1003, 32'd4, 5'd1, 2'd1, 1, 1);
        step(0, 1, 0, 0, 32'h22);
        check("strb_misaligned", w_strb, 4'b0000);
        check("strb_nonempty", fifo_empty, 1'b0);
        load(32'h0, 32'h1002, 32'd4, 5'd1, 2'd1, 1, 1);
        step(0, 1, 0, 0, 32'h33);
        check("strb_half_hi", w_strb, 4'b1100);
        load(32'h0, 32'h1004, 32'd4, 5'd1, 2'd2, 1, 1);
        step(0, 1, 0, 0, 32'h44);
        check("strb_word", w_strb, 4'b1111);

        // FIFO limits and bypass
        load(32'h0, 32'h0, 32'd40, 5'd1, 2'd2, 1, 1);
        for (int i = 0; i < 16; i++) step(0, 1, 0, 0, 32'(i));
        check("fifo_full16", fifo_full, 1'b1);
        step(0, 1, 0, 0, 32'hDEAD);
        check("ovf_set", ovf_err, 1'b1);
        check("ovf_level", fifo_level, 5'd16);
        step(0, 1, 0, 1, 32'h77);
        check("full_pushpop_level", fifo_level, 5'd16);
        check("full_pushpop_head", w_data, 32'h1);
        repeat (17) step(0, 0, 0, 1, '0);
        check("unf_set", unf_err, 1'b1);
        check("unf_level", fifo_level, 5'd0);
        step(0, 1, 0, 1, 32'hBEEF);
        check("bypass_data", w_data, 32'hBEEF);
        check("bypass_empty", fifo_empty, 1'b1);
        load(32'h0, 32'h0, 32'd4, 5'd1, 2'd2, 1, 1);
        check("cfg_clr_ovf", ovf_err, 1'b0);
        check("cfg_clr_unf", unf_err, 1'b0);

        // Reset in the middle of a transfer
        load(32'h100, 32'h2000, 32'd16, 5'd4, 2'd2, 1, 1);
        step(1, 0, 0, 0, '0);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 32'(i));
        step(1, 0, 0, 0, '0);
        step(0, 1, 0, 0, 32'h4);
        #2;
        rst = 0;
        #1;
        check("mid_rst_src", src_addr, 32'h0);
        check("mid_rst_level", fifo_level, 5'd0);
        check("mid_rst_done", rd_done, 1'b1);
        check("mid_rst_hburst", rd_hburst, 3'b000);
        check("mid_rst_last", rd_burst_last, 1'b1);
        check("mid_rst_wdata", w_data, 32'h0);
        @(negedge clk);
        #1;
        rst = 1;
        run_basic();

        chk_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
